// File: rtl/seg_pkg.sv
// seg_pkg: shared types, constants and decode helpers for seg_scanner.
// Used by the 7-segment scanner running in the pixel_clk domain.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } seg_state_e;

    // Active-low segments: all off, decimal point off
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Hex nibble to active-low {dp, g..a}; dp stays dark here
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] s;
        unique case (nib)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            4'hF: s = 8'h8E;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    // Cycles per digit slot; never below one cycle
    function automatic int calc_tick_div(input int clk_hz, input int scan_hz);
        int q;
        q = clk_hz / scan_hz;
        return (q < 1) ? 1 : q;
    endfunction

endpackage

// File: rtl/seg_scanner.sv
// seg_scanner: multiplexed common-anode 7-segment driver with dead time.
// Optional leading-zero blanking when SEG_SCANNER_LZ_BLANK_EN is defined.
module seg_scanner
    import seg_pkg::*;
#(
    parameter int CLK_HZ       = 25_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int NUM_DIGITS   = 3,
    parameter int BLANK_CYCLES = 64,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_out,
    output logic [IDX_W-1:0]        digit_idx
);

    localparam int TICK_DIV  = calc_tick_div(CLK_HZ, SCAN_HZ);
    localparam int DRIVE_LEN = TICK_DIV - BLANK_CYCLES;
    localparam int CNT_W     = $clog2(TICK_DIV + 1);

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST =
        CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam bit HAS_GAP = (BLANK_CYCLES > 0);

    if (BLANK_CYCLES >= TICK_DIV || BLANK_CYCLES < 0) begin : g_blank_err
        $error("seg_scanner: BLANK_CYCLES must be >= 0 and < TICK_DIV");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_ndig_err
        $error("seg_scanner: NUM_DIGITS must be in 1..8");
    end

    seg_state_e              state_q;
    seg_state_e              state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_d;
    logic [7:0]              seg_q;
    logic [7:0]              seg_d;
    logic [NUM_DIGITS-1:0]   dig_q;
    logic [NUM_DIGITS-1:0]   dig_d;

    logic [4*NUM_DIGITS-1:0] sh_dig;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   lz_blank;

    logic                    drive_done;
    logic                    gap_done;
    logic                    entering;
    logic [IDX_W-1:0]        idx_next;
    logic [IDX_W-1:0]        tgt_idx;
    logic [3:0]              tgt_nib;
    logic [7:0]              tgt_pat;
    logic [NUM_DIGITS-1:0]   tgt_sel;

    assign drive_done = (cnt_q == DRIVE_LAST);
    assign gap_done   = (cnt_q == GAP_LAST);
    assign idx_next   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

    // Shadow copy of the display value; loads are accepted in every state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_dig <= '0;
            sh_dp  <= '0;
        end else if (load) begin
            sh_dig <= digits_in;
            sh_dp  <= dp_in;
        end
    end

`ifdef SEG_SCANNER_LZ_BLANK_EN
    // A digit is blank when it and every higher nibble are zero and no dp
    always_comb begin
        logic hi_zero;
        lz_blank = '0;
        hi_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            hi_zero = hi_zero && (sh_dig[4*i +: 4] == 4'h0);
            lz_blank[i] = (i > 0) && hi_zero && !sh_dp[i];
        end
    end
`else
    // Every digit always shows its nibble
    assign lz_blank = '0;
`endif

    // Scan sequencing, slot counter and registered pin drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_OFF;
            dig_q   <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
        end
    end

    // Next state: disable wins, otherwise walk DRIVE/GAP slots
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = DRIVE;
                DRIVE: begin
                    if (drive_done) state_d = HAS_GAP ? GAP : DRIVE;
                end
                GAP: begin
                    if (gap_done) state_d = DRIVE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Pattern of the digit about to be driven, sampled from the shadow
    always_comb begin
        tgt_idx = (state_q == IDLE) ? '0 : idx_next;
        tgt_nib = sh_dig[4*int'(tgt_idx) +: 4];
        tgt_pat = hex_to_seg(tgt_nib);
        if (sh_dp[tgt_idx]) tgt_pat[7] = 1'b0;
        if (lz_blank[tgt_idx]) tgt_pat = SEG_OFF;
        tgt_sel = '1;
        tgt_sel[tgt_idx] = 1'b0;
    end

    // Outputs and counter for the coming cycle; pattern frozen per slot
    always_comb begin
        entering = (state_d == DRIVE) && !(state_q == DRIVE && !drive_done);
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        seg_d = seg_q;
        dig_d = dig_q;
        if (state_d == IDLE) begin
            cnt_d = '0;
            idx_d = '0;
            seg_d = SEG_OFF;
            dig_d = '1;
        end else if (entering) begin
            cnt_d = '0;
            idx_d = tgt_idx;
            seg_d = tgt_pat;
            dig_d = tgt_sel;
        end else if (state_d != state_q) begin
            cnt_d = '0;
            seg_d = SEG_OFF;
            dig_d = '1;
        end
    end

    assign seg_out   = seg_q;
    assign dig_out   = dig_q;
    assign digit_idx = idx_q;

endmodule

// File: doc/seg_scanner.md
Name: seg_scanner

Overview:
- Time-multiplexed 7-segment display driver for the board's 3-digit common-anode display (SMG_SEG / SMG_DIG).
- Runs in the pixel_clk domain next to the VGA chain.
- Consumes packed hex digits and decimal points from status logic; drives the segment and digit-select pins directly.
- Adds coherent digit loading, anti-ghosting dead time between digits, and a clean enable/disable.

Parameters:
- CLK_HZ, 25_000_000: input clock frequency in Hz.
- SCAN_HZ, 1000: digit slot rate in Hz (one slot per digit).
- NUM_DIGITS, 3: number of multiplexed digits (1..8).
- BLANK_CYCLES, 64: dead-time cycles per slot with all digits off. Must be < TICK_DIV; elaboration error otherwise.

Ports:
- clk  in  1  clock (pixel_clk)
- rst  in  1  asynchronous reset, active-high
- enable  in  1  scanning enabled; low forces display dark
- load  in  1  single-cycle strobe; latches digits_in/dp_in into the shadow registers
- digits_in  in  4*NUM_DIGITS  hex nibbles; nibble 0 = rightmost digit
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
- seg_out  out  8  segments, active-low; bit7 = dp, bits6..0 = g..a
- dig_out  out  NUM_DIGITS  digit select, active-low; bit0 = digit 0
- digit_idx  out  $clog2(NUM_DIGITS) (min 1)  index of the currently driven or last driven digit

Behaviour:
- Timing constants:
  - TICK_DIV = max(1, CLK_HZ/SCAN_HZ), integer division.
  - DRIVE_LEN = TICK_DIV - BLANK_CYCLES.
  - One slot is exactly TICK_DIV cycles.
- Reset (async, rst=1): state=IDLE, seg_out=8'hFF, dig_out all 1, digit_idx=0, slot counter=0, shadow digits=0, shadow dp=0.
- Shadow registers:
  - On load=1, shadow takes digits_in/dp_in at that edge.
  - load is accepted in every state, including IDLE.
  - Digit pattern is sampled from shadow only on entry to DRIVE. A load mid-slot therefore affects the next slot, never the current one (no intra-slot glitch).
- FSM states IDLE, DRIVE, GAP. All outputs are registered.
  - IDLE:
    - Outputs dark (seg 8'hFF, dig all 1), counter 0, digit_idx 0.
    - enable=1 → next edge enters DRIVE for digit 0. Outputs are valid on that edge, i.e. 1-cycle latency from enable.
  - DRIVE:
    - dig_out has only bit digit_idx low.
    - seg_out = hex_to_seg(shadow nibble) with bit7 cleared if dp.
    - Lasts DRIVE_LEN cycles. Then GAP if BLANK_CYCLES>0; otherwise DRIVE of the next digit directly.
  - GAP:
    - dig_out all 1, seg_out 8'hFF.
    - Lasts BLANK_CYCLES cycles, then DRIVE of the next digit.
- Digit advance: digit_idx increments on DRIVE entry and wraps NUM_DIGITS-1 → 0.
- enable=0 in any state: next edge goes to IDLE (dark, counter and idx cleared). Re-enable always restarts at digit 0 with a full slot.
- Hex decode, active-low gfedcba:
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8
  - 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E (bit7 = 1 before dp).
- NUM_DIGITS=1: idx stays 0; DRIVE/GAP alternate on the same digit.
- Counter width $clog2(TICK_DIV+1). No overflow is possible; the counter is cleared at each state change.

Optional Feature:
- Macro SEG_SCANNER_LZ_BLANK_EN: leading-zero blanking.
- With the macro defined: a digit i>0 is blanked if its nibble and all higher nibbles in the shadow are 0 and its dp bit is 0. A blanked digit still occupies its DRIVE slot with seg_out=8'hFF and dig_out selected. Digit 0 is never blanked.
- Without the macro: all digits always show their nibble.

Decomposition:
- Shared package seg_pkg:
  - seg_state_e {IDLE, DRIVE, GAP}
  - SEG_OFF = 8'hFF
  - automatic function hex_to_seg(logic [3:0]) returning logic [7:0]
  - calc_tick_div(CLK_HZ, SCAN_HZ) helper
- No sub-module: the prescaler and FSM are a single always_ff; the decode is a package function.

Test Plan (CLK_HZ=1000, SCAN_HZ=100 → TICK_DIV=10, BLANK_CYCLES=2, NUM_DIGITS=3):
- Reset held, then released with enable=0 → seg_out=8'hFF, dig_out=3'b111, digit_idx=0 indefinitely.
- load digits_in=12'h321, dp_in=0, then enable=1 → next edge: dig_out=3'b110, seg_out=8'hF9 for 8 cycles; then 2 cycles dark; then 3'b101/8'hA4; then 3'b011/8'hB0; wraps to digit 0 at cycle 30.
- Pulse load with 12'hABC mid-DRIVE of digit 0 → digit 0 keeps F9 until its slot ends; digit 1 shows 8'h83 (b); digit 2 shows 8'h88 (A).
- dp_in=3'b010 with 12'h000 → digit 1 seg_out=8'h40; digits 0/2 show 8'hC0. With SEG_SCANNER_LZ_BLANK_EN: digit 2 is 8'hFF, digit 1 is 8'h40, digit 0 is 8'hC0.
- Deassert enable during GAP of digit 1 → next edge dark, digit_idx=0. Re-enable → DRIVE of digit 0 with a full 8-cycle slot.
- Assert rst asynchronously mid-DRIVE (between edges) → outputs go dark immediately, shadow cleared. After release with enable=1, digit 0 shows 8'hC0.
